// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared sizes, state and error encodings for the matrix loader
package matrix_pkg;

    localparam int MAX_DIM   = 5;
    localparam int MAX_ELEMS = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_FULL = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DIM     = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_code_t;

    // A dimension is usable when it lies in 1..MAX_DIM.
    function automatic logic dim_ok(input logic [2:0] d);
        return (d != 3'd0) && (d <= 3'(MAX_DIM));
    endfunction

    // 3x3-bit product into 6 bits; valid dimensions never exceed 25, so 5 bits hold it.
    function automatic logic [4:0] dim_product(input logic [2:0] r, input logic [2:0] c);
        logic [5:0] p;
        p = {3'b000, r} * {3'b000, c};
        return 5'(p);
    endfunction

endpackage

// File: rtl/matrix_loader_beat_timeout.sv
// rtl/matrix_loader_beat_timeout.sv - idle-cycle watchdog between accepted beats
module beat_timeout #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_arm,
    input  logic i_kick,
    output logic o_expired
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // r_cnt holds the number of cycles elapsed since the last kick (or since arming),
    // counting the current cycle, so expiry lands TIMEOUT_CYCLES-1 cycles after the beat
    // and the registered error shows up exactly TIMEOUT_CYCLES cycles after it.
    logic [CW-1:0] r_cnt;

    assign o_expired = (TIMEOUT_CYCLES != 0) && i_arm && !i_kick &&
                       (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Restart on every kick or while disarmed, otherwise count up and hold at expiry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_arm || i_kick) begin
            r_cnt <= CW'(1);
        end else if (!o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - packs a serial element stream row-major into a 25-slot matrix buffer
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int DATA_WIDTH     = 9,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [2:0]                      i_r_in,
    input  logic [2:0]                      i_c_in,
    input  logic                            i_in_valid,
    input  logic [DATA_WIDTH-1:0]           i_in_data,
    output logic                            o_in_ready,
    input  logic                            i_abort,
    input  logic                            i_release,
    output logic [2:0]                      o_r_out,
    output logic [2:0]                      o_c_out,
    output logic [MAX_ELEMS*DATA_WIDTH-1:0] o_data_flat,
    output logic                            o_mat_valid,
    output logic [4:0]                      o_load_count,
    output logic                            o_err,
    output logic [1:0]                      o_err_code
);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_r;
    logic [2:0]            r_c;
    logic [4:0]            r_total;
    logic [4:0]            r_count;
    logic [DATA_WIDTH-1:0] r_data [MAX_ELEMS];
    logic                  r_in_ready;
    logic                  r_mat_valid;
    logic                  r_err;
    err_code_t             r_err_code;

    logic                  w_start_ok;
    logic                  w_dim_err;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_expired;
    logic [MAX_ELEMS-1:0]  w_onehot;

    // A beat counts only when it is not cancelled by a coincident abort.
    assign w_accept = (r_state == ST_LOAD) && i_in_valid && !i_abort;
    assign w_abort  = (r_state == ST_LOAD) && (i_abort || w_expired);
    assign w_onehot = MAX_ELEMS'(1) << r_count;

    beat_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_arm    (r_state == ST_LOAD),
        .i_kick   (w_accept),
        .o_expired(w_expired)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode and the control strobes that steer the datapath.
    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_dim_err  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (dim_ok(i_r_in) && dim_ok(i_c_in)) begin
                        w_start_ok = 1'b1;
                        w_next     = ST_LOAD;
                    end else begin
                        w_dim_err  = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_abort)                                      w_next = ST_IDLE;
                else if (w_accept && (r_count + 5'd1 == r_total)) w_next = ST_FULL;
            end
            ST_FULL: begin
                if (i_release) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath: dimensions, element buffer, beat counter, error reporting and the
    // registered handshake/level outputs (kept as flops so mat_valid cannot glitch).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_r         <= '0;
            r_c         <= '0;
            r_total     <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_mat_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            for (int k = 0; k < MAX_ELEMS; k++) r_data[k] <= '0;
        end else begin
            r_in_ready  <= (w_next == ST_LOAD);
            r_mat_valid <= (w_next == ST_FULL);
            r_err       <= w_dim_err || w_expired;

            if (w_dim_err)       r_err_code <= ERR_DIM;
            else if (w_start_ok) r_err_code <= ERR_NONE;
            else if (w_expired)  r_err_code <= ERR_TIMEOUT;

            if (w_start_ok) begin
                r_r     <= i_r_in;
                r_c     <= i_c_in;
                r_total <= dim_product(i_r_in, i_c_in);
                r_count <= '0;
                for (int k = 0; k < MAX_ELEMS; k++) r_data[k] <= '0;
            end else if (w_abort) begin
                r_r     <= '0;
                r_c     <= '0;
                r_count <= '0;
                for (int k = 0; k < MAX_ELEMS; k++) r_data[k] <= '0;
            end else if (w_accept) begin
                for (int k = 0; k < MAX_ELEMS; k++) begin
                    if (w_onehot[k]) r_data[k] <= i_in_data;
                end
                r_count <= r_count + 5'd1;
            end
        end
    end

    // Flatten the buffer onto the output bus, slot k at bits [k*DATA_WIDTH +: DATA_WIDTH].
    always_comb begin
        o_data_flat = '0;
        for (int k = 0; k < MAX_ELEMS; k++) begin
            o_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = r_data[k];
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_mat_valid  = r_mat_valid;
    assign o_r_out      = r_r;
    assign o_c_out      = r_c;
    assign o_load_count = r_count;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed, table-driven bench for matrix_loader
module tb_matrix_loader;

    localparam int DW = 9;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    r_in;
    logic [2:0]    c_in;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          abort_i;
    logic          release_i;
    logic [2:0]    r_out;
    logic [2:0]    c_out;
    logic [25*DW-1:0] data_flat;
    logic          mat_valid;
    logic [4:0]    load_count;
    logic          err;
    logic [1:0]    err_code;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0] r;
        logic [2:0] c;
        bit         ok;
        int         total;
    } vec_t;

    vec_t vecs [7];

    matrix_loader #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_r_in      (r_in),
        .i_c_in      (c_in),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .i_abort     (abort_i),
        .i_release   (release_i),
        .o_r_out     (r_out),
        .o_c_out     (c_out),
        .o_data_flat (data_flat),
        .o_mat_valid (mat_valid),
        .o_load_count(load_count),
        .o_err       (err),
        .o_err_code  (err_code)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int slot(input int k);
        return int'(data_flat[k*DW +: DW]);
    endfunction

    task automatic do_start(input logic [2:0] r, input logic [2:0] c);
        start = 1'b1; r_in = r; c_in = c;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " in_ready"},   int'(in_ready), 0);
        chk({nm, " mat_valid"},  int'(mat_valid), 0);
        chk({nm, " data_zero"},  int'(|data_flat), 0);
        chk({nm, " load_count"}, int'(load_count), 0);
        chk({nm, " r_out"},      int'(r_out), 0);
        chk({nm, " c_out"},      int'(c_out), 0);
    endtask

    initial begin
        int prev_r;
        int k;
        int cyc;

        vecs[0] = '{r: 3'd0, c: 3'd4, ok: 1'b0, total: 0};
        vecs[1] = '{r: 3'd6, c: 3'd1, ok: 1'b0, total: 0};
        vecs[2] = '{r: 3'd1, c: 3'd7, ok: 1'b0, total: 0};
        vecs[3] = '{r: 3'd5, c: 3'd5, ok: 1'b1, total: 25};
        vecs[4] = '{r: 3'd3, c: 3'd4, ok: 1'b1, total: 12};
        vecs[5] = '{r: 3'd1, c: 3'd5, ok: 1'b1, total: 5};
        vecs[6] = '{r: 3'd4, c: 3'd1, ok: 1'b1, total: 4};

        reset = 1'b1; start = 1'b0; r_in = '0; c_in = '0;
        in_valid = 1'b0; in_data = '0; abort_i = 1'b0; release_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        check_all_zero("reset");
        chk("reset err", int'(err), 0);
        chk("reset err_code", int'(err_code), 0);

        // Full 2x3 load, back-to-back beats.
        do_start(3'd2, 3'd3);
        chk("2x3 in_ready after start", int'(in_ready), 1);
        for (int b = 1; b <= 6; b++) begin
            in_valid = 1'b1; in_data = DW'(b);
            step();
        end
        in_data = DW'(99);
        chk("2x3 mat_valid", int'(mat_valid), 1);
        chk("2x3 in_ready low", int'(in_ready), 0);
        for (int s = 0; s < 25; s++) chk($sformatf("2x3 slot%0d", s), slot(s), (s < 6) ? s + 1 : 0);
        chk("2x3 r_out", int'(r_out), 2);
        chk("2x3 c_out", int'(c_out), 3);
        chk("2x3 load_count", int'(load_count), 6);
        step();
        in_valid = 1'b0;
        chk("2x3 no extra beat count", int'(load_count), 6);
        chk("2x3 no extra beat slot6", slot(6), 0);
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        chk("2x3 mat_valid after release", int'(mat_valid), 0);
        prev_r = 2;

        // Dimension table: bad dims pulse err, good dims load to FULL.
        for (int i = 0; i < 7; i++) begin
            do_start(vecs[i].r, vecs[i].c);
            if (!vecs[i].ok) begin
                chk($sformatf("vec%0d err", i), int'(err), 1);
                chk($sformatf("vec%0d err_code", i), int'(err_code), 1);
                chk($sformatf("vec%0d in_ready", i), int'(in_ready), 0);
                chk($sformatf("vec%0d r_out kept", i), int'(r_out), prev_r);
                step();
                chk($sformatf("vec%0d err one cycle", i), int'(err), 0);
                chk($sformatf("vec%0d err_code held", i), int'(err_code), 1);
            end else begin
                chk($sformatf("vec%0d in_ready", i), int'(in_ready), 1);
                chk($sformatf("vec%0d err_code cleared", i), int'(err_code), 0);
                for (int b = 0; b < vecs[i].total; b++) begin
                    in_valid = 1'b1; in_data = DW'(i * 10 + b + 1);
                    step();
                end
                in_valid = 1'b0;
                chk($sformatf("vec%0d mat_valid", i), int'(mat_valid), 1);
                chk($sformatf("vec%0d load_count", i), int'(load_count), vecs[i].total);
                chk($sformatf("vec%0d first slot", i), slot(0), i * 10 + 1);
                chk($sformatf("vec%0d last slot", i), slot(vecs[i].total - 1), i * 10 + vecs[i].total);
                if (vecs[i].total < 25)
                    chk($sformatf("vec%0d unused slot", i), slot(vecs[i].total), 0);
                release_i = 1'b1;
                step();
                release_i = 1'b0;
                prev_r = int'(vecs[i].r);
            end
        end

        // Gapped 5x5 load: in_valid every other cycle, values k+100.
        do_start(3'd5, 3'd5);
        k = 0;
        cyc = 0;
        while (k < 25 && cyc < 200) begin
            in_valid = (cyc % 2 == 0);
            in_data  = DW'(k + 100);
            step();
            if (in_valid) k++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("gap beats within budget", k, 25);
        chk("gap mat_valid", int'(mat_valid), 1);
        chk("gap in_ready low", int'(in_ready), 0);
        chk("gap slot24", slot(24), 124);
        chk("gap slot0", slot(0), 100);
        chk("gap slot12", slot(12), 112);
        chk("gap load_count", int'(load_count), 25);
        release_i = 1'b1;
        step();
        release_i = 1'b0;

        // Abort colliding with beat 5 of a 3x3 load.
        do_start(3'd3, 3'd3);
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_data = DW'(11 + b);
            step();
        end
        chk("abort pre count", int'(load_count), 4);
        in_valid = 1'b1; in_data = DW'(15); abort_i = 1'b1;
        step();
        in_valid = 1'b0; abort_i = 1'b0;
        check_all_zero("abort");

        // Timeout: two beats of a 3x3 load, then silence.
        do_start(3'd3, 3'd3);
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_data = DW'(40 + b);
            step();
        end
        in_valid = 1'b0;
        for (int t = 0; t < TO - 2; t++) step();
        chk("timeout no early err", int'(err), 0);
        chk("timeout still loading", int'(in_ready), 1);
        chk("timeout slot1 before expiry", slot(1), 41);
        step();
        chk("timeout err", int'(err), 1);
        chk("timeout err_code", int'(err_code), 2);
        check_all_zero("timeout");
        step();
        chk("timeout err one cycle", int'(err), 0);
        chk("timeout err_code held", int'(err_code), 2);

        // 1x1 load, FULL ignores abort/start, release keeps the buffer.
        do_start(3'd1, 3'd1);
        in_valid = 1'b1; in_data = DW'(9'h1FF);
        step();
        in_valid = 1'b0;
        chk("1x1 mat_valid", int'(mat_valid), 1);
        chk("1x1 slot0", slot(0), 511);
        abort_i = 1'b1; start = 1'b1; r_in = 3'd2; c_in = 3'd2;
        step();
        abort_i = 1'b0; start = 1'b0;
        chk("full ignores abort", int'(mat_valid), 1);
        chk("full ignores start r_out", int'(r_out), 1);
        chk("full keeps slot0", slot(0), 511);
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        chk("release mat_valid", int'(mat_valid), 0);
        chk("release slot0 kept", slot(0), 511);
        chk("release r_out kept", int'(r_out), 1);

        // Reset during FULL.
        do_start(3'd1, 3'd1);
        in_valid = 1'b1; in_data = DW'(9'h0AA);
        step();
        in_valid = 1'b0;
        chk("pre-reset mat_valid", int'(mat_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("reset in full");
        chk("reset in full err_code", int'(err_code), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
